// File: rtl/tlc_pkg.sv
// Shared state codes, lamp encodings and per-state lamp decode for the
// highway/local-road intersection controller.
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_HW_G  = 3'd0,
        ST_HW_Y  = 3'd1,
        ST_AR1   = 3'd2,
        ST_LR_G  = 3'd3,
        ST_LR_Y  = 3'd4,
        ST_AR2   = 3'd5,
        ST_FLASH = 3'd6
    } tlc_state_t;

    localparam logic [2:0] LAMP_GREEN  = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    // FLASH returns the lit half of the flash pattern; the top blanks it.
    function automatic logic [2:0] hw_lamp(input tlc_state_t s);
        case (s)
            ST_HW_G:  hw_lamp = LAMP_GREEN;
            ST_HW_Y:  hw_lamp = LAMP_YELLOW;
            ST_FLASH: hw_lamp = LAMP_YELLOW;
            default:  hw_lamp = LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] lr_lamp(input tlc_state_t s);
        case (s)
            ST_LR_G: lr_lamp = LAMP_GREEN;
            ST_LR_Y: lr_lamp = LAMP_YELLOW;
            default: lr_lamp = LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating phase counter: cleared on reset or clr, otherwise counts up and
// holds at all-ones. done flags that the current phase duration has elapsed.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] dur,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // >= rather than == so the highway-green minimum stays satisfied while waiting.
    assign done = (cnt >= dur - CNT_W'(1));

endmodule

// File: rtl/param_traffic_light_controller.sv
// Parametrised highway/local-road intersection controller with latched
// pedestrian service. Night flashing is built only with TLC_NIGHT_FLASH_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_HW_G  | highway green, held until min time elapsed and a request
// ST_HW_Y  | highway yellow
// ST_AR1   | all red, clearing toward local road
// ST_LR_G  | local-road green, walk lit if a pedestrian was waiting
// ST_LR_Y  | local-road yellow
// ST_AR2   | all red, clearing toward highway
// ST_FLASH | night flashing (yellow highway, red local road)
module param_traffic_light_controller
    import tlc_pkg::*;
#(
    parameter int HW_GREEN_MIN = 70,
    parameter int LR_GREEN     = 70,
    parameter int YELLOW       = 25,
    parameter int ALL_RED      = 1,
    parameter int CNT_W        = 8,
    parameter int FLASH_HALF   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lr_has_car,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] hw_light,
    output logic [2:0] lr_light,
    output logic       walk,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] D_HW_MIN   = CNT_W'(HW_GREEN_MIN);
    localparam logic [CNT_W-1:0] D_LR_GREEN = CNT_W'(LR_GREEN);
    localparam logic [CNT_W-1:0] D_YELLOW   = CNT_W'(YELLOW);
    localparam logic [CNT_W-1:0] D_ALL_RED  = CNT_W'(ALL_RED);

    tlc_state_t       state_q;
    tlc_state_t       nxt;
    logic             ped_pending;
    logic [CNT_W-1:0] dur;
    logic             tmr_done;
    logic             svc_req;

    assign svc_req = lr_has_car | ped_pending | ped_req;
    assign state   = state_q;

    always_comb begin
        dur = D_HW_MIN;
        case (state_q)
            ST_HW_Y, ST_LR_Y: dur = D_YELLOW;
            ST_AR1, ST_AR2:   dur = D_ALL_RED;
            ST_LR_G:          dur = D_LR_GREEN;
            default:          dur = D_HW_MIN;
        endcase
    end

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (nxt != state_q),
        .dur  (dur),
        .done (tmr_done)
    );

    always_comb begin
        nxt = state_q;
        case (state_q)
            ST_HW_G: begin
                if (tmr_done) begin
`ifdef TLC_NIGHT_FLASH_EN
                    if (night) begin
                        nxt = ST_FLASH;
                    end else if (svc_req) begin
                        nxt = ST_HW_Y;
                    end
`else
                    if (svc_req) begin
                        nxt = ST_HW_Y;
                    end
`endif
                end
            end
            ST_HW_Y: if (tmr_done) nxt = ST_AR1;
            ST_AR1:  if (tmr_done) nxt = ST_LR_G;
            ST_LR_G: if (tmr_done) nxt = ST_LR_Y;
            ST_LR_Y: if (tmr_done) nxt = ST_AR2;
            ST_AR2:  if (tmr_done) nxt = ST_HW_G;
`ifdef TLC_NIGHT_FLASH_EN
            ST_FLASH: if (!night) nxt = ST_AR2;
`else
            ST_FLASH: nxt = ST_HW_G;
`endif
            default: nxt = ST_HW_G;
        endcase
    end

`ifdef TLC_NIGHT_FLASH_EN
    localparam logic [CNT_W-1:0] D_FLASH_LAST = CNT_W'(FLASH_HALF - 1);

    logic             flash_on_q;
    logic             flash_on_nxt;
    logic [CNT_W-1:0] flash_cnt_q;
    logic [CNT_W-1:0] flash_cnt_nxt;

    // Entering FLASH always starts on the lit half.
    always_comb begin
        flash_on_nxt  = 1'b1;
        flash_cnt_nxt = '0;
        if (state_q == ST_FLASH && nxt == ST_FLASH) begin
            if (flash_cnt_q == D_FLASH_LAST) begin
                flash_on_nxt = ~flash_on_q;
            end else begin
                flash_on_nxt  = flash_on_q;
                flash_cnt_nxt = flash_cnt_q + CNT_W'(1);
            end
        end
    end
`else
    logic unused_night;
    assign unused_night = night;
    localparam int unused_flash_half = FLASH_HALF;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HW_G;
            ped_pending <= 1'b0;
            hw_light    <= LAMP_GREEN;
            lr_light    <= LAMP_RED;
            walk        <= 1'b0;
`ifdef TLC_NIGHT_FLASH_EN
            flash_on_q  <= 1'b1;
            flash_cnt_q <= '0;
`endif
        end else begin
            state_q <= nxt;

            // A press on the service edge itself is kept for the next cycle.
            if (state_q == ST_AR1 && nxt == ST_LR_G) begin
                ped_pending <= ped_req;
            end else if (ped_req) begin
                ped_pending <= 1'b1;
            end

            if (state_q == ST_AR1 && nxt == ST_LR_G) begin
                walk <= ped_pending;
            end else if (nxt != ST_LR_G) begin
                walk <= 1'b0;
            end

            hw_light <= hw_lamp(nxt);
            lr_light <= lr_lamp(nxt);
`ifdef TLC_NIGHT_FLASH_EN
            flash_on_q  <= flash_on_nxt;
            flash_cnt_q <= flash_cnt_nxt;
            if (nxt == ST_FLASH && !flash_on_nxt) begin
                hw_light <= LAMP_OFF;
                lr_light <= LAMP_OFF;
            end
`endif
        end
    end

endmodule
